// File: rtl/move_sequencer.sv
// Move sequencer for the 4x4 tile grid: injects a move token into the lanes, waits for completion,
// scores merges, spawns new tiles through the preset path and detects game over.
module move_sequencer #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned SCORE_W   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_dir,
  input  logic               new_game,
  input  logic [3:0]         lane_done,
  input  logic [15:0]        score_in,
  input  logic [63:0]        board_in,
  input  logic [63:0]        movable_in,
  output logic [3:0]         inject_dir,
  output logic [15:0]        preset_strobe,
  output logic [3:0]         preset_value,
  output logic               busy,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    CLEAR, IDLE, INJECT, WAIT, SETTLE, SEARCH, SPAWN, CHECK, OVER
  } state_t;

  state_t             state_reg, state_next;
  logic               run_reg;
  logic [15:0]        lfsr_reg;
  logic [3:0]         dir_reg;
  logic [63:0]        snapshot_reg;
  logic [3:0]         sticky_reg;
  logic [TW-1:0]      timer_reg;
  logic [3:0]         idx_reg;
  logic [3:0]         tested_reg;
  logic [1:0]         spawn_cnt_reg;
  logic [SCORE_W-1:0] score_reg;
  logic               game_over_reg;
  logic               timeout_err_reg;

  logic               key_one_hot;
  logic [3:0]         sticky_now;
  logic [3:0]         cell_val;
  logic               wait_expired;
  logic [4:0]         merge_cnt;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_add;
  logic               lfsr_fb;

  assign key_one_hot  = (key_dir != 4'd0) && ((key_dir & (key_dir - 4'd1)) == 4'd0);
  assign sticky_now   = sticky_reg | lane_done;
  assign cell_val     = board_in[{idx_reg, 2'b00} +: 4];
  assign wait_expired = (sticky_now != 4'hF) && (timer_reg == TW'(TIMEOUT - 1));
  assign lfsr_fb      = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // Merge count is a popcount of the per-node pulses; the accumulator saturates.
  always_comb begin
    merge_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      merge_cnt = merge_cnt + {4'd0, score_in[i]};
    end
    score_sum = {1'b0, score_reg} + {{(SCORE_W - 4){1'b0}}, merge_cnt};
    score_add = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR:  if (run_reg) state_next = SEARCH;
      IDLE:   if (key_valid && key_one_hot) state_next = INJECT;
      INJECT: state_next = WAIT;
      WAIT: begin
        if (sticky_now == 4'hF) state_next = SETTLE;
        else if (wait_expired)  state_next = IDLE;
      end
      SETTLE: state_next = (board_in != snapshot_reg) ? SEARCH : CHECK;
      SEARCH: begin
        if (cell_val == 4'd0)        state_next = SPAWN;
        else if (tested_reg == 4'd15) state_next = CHECK;
      end
      SPAWN:  state_next = (spawn_cnt_reg > 2'd1) ? SEARCH : CHECK;
      CHECK:  state_next = (movable_in == 64'd0) ? OVER : IDLE;
      OVER:   state_next = OVER;
      default: state_next = CLEAR;
    endcase
    if (new_game) state_next = CLEAR;
  end

  // run_reg keeps every output quiet while reset is held, then lets CLEAR act.
  always_comb begin
    inject_dir    = 4'd0;
    preset_strobe = 16'd0;
    preset_value  = 4'd0;
    busy          = run_reg && (state_reg != IDLE) && (state_reg != OVER);
    if (run_reg) begin
      case (state_reg)
        CLEAR:  preset_strobe = 16'hFFFF;
        INJECT: inject_dir = dir_reg;
        SPAWN: begin
          preset_strobe = 16'd1 << idx_reg;
          preset_value  = (lfsr_reg[7:4] == 4'd0) ? 4'd2 : 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign score       = score_reg;
  assign game_over   = game_over_reg;
  assign timeout_err = timeout_err_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= CLEAR;
      run_reg         <= 1'b0;
      lfsr_reg        <= LFSR_SEED;
      dir_reg         <= 4'd0;
      snapshot_reg    <= 64'd0;
      sticky_reg      <= 4'd0;
      timer_reg       <= '0;
      idx_reg         <= 4'd0;
      tested_reg      <= 4'd0;
      spawn_cnt_reg   <= 2'd0;
      score_reg       <= '0;
      game_over_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      run_reg   <= 1'b1;
      state_reg <= state_next;
      lfsr_reg  <= {lfsr_reg[14:0], lfsr_fb};
      case (state_reg)
        CLEAR: if (run_reg) spawn_cnt_reg <= 2'd2;
        IDLE: begin
          if (key_valid && key_one_hot) begin
            dir_reg      <= key_dir;
            snapshot_reg <= board_in;
            sticky_reg   <= 4'd0;
          end
        end
        INJECT: timer_reg <= '0;
        WAIT: begin
          sticky_reg <= sticky_now;
          score_reg  <= score_add;
          timer_reg  <= timer_reg + TW'(1);
          if (wait_expired) timeout_err_reg <= 1'b1;
        end
        SETTLE: begin
          score_reg <= score_add;
          if (board_in != snapshot_reg) spawn_cnt_reg <= 2'd1;
        end
        SEARCH: begin
          if (cell_val != 4'd0) begin
            idx_reg    <= idx_reg + 4'd1;
            tested_reg <= tested_reg + 4'd1;
          end
        end
        SPAWN: spawn_cnt_reg <= spawn_cnt_reg - 2'd1;
        CHECK: if (movable_in == 64'd0) game_over_reg <= 1'b1;
        default: ;
      endcase
      // Each search pass starts from a fresh random cell.
      if (state_next == SEARCH && state_reg != SEARCH) begin
        idx_reg    <= lfsr_reg[3:0];
        tested_reg <= 4'd0;
      end
      if (new_game) begin
        score_reg       <= '0;
        game_over_reg   <= 1'b0;
        timeout_err_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus randomized moves against
// a board/score model that reacts to the preset and inject outputs.
module tb_move_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_dir;
  logic        new_game;
  logic [3:0]  lane_done;
  logic [15:0] score_in;
  logic [63:0] board_in;
  logic [63:0] movable_in;
  logic [3:0]  inject_dir;
  logic [15:0] preset_strobe;
  logic [3:0]  preset_value;
  logic        busy;
  logic [15:0] score;
  logic        game_over;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int spawns = 0;
  int clears = 0;
  int inj_cycles = 0;
  int exp_score = 0;
  bit in_wait = 0;
  logic [63:0] board_vec = 64'd0;

  assign board_in = board_vec;

  always #5 clk = ~clk;

  move_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_dir(key_dir), .new_game(new_game),
    .lane_done(lane_done), .score_in(score_in), .board_in(board_in), .movable_in(movable_in),
    .inject_dir(inject_dir), .preset_strobe(preset_strobe), .preset_value(preset_value),
    .busy(busy), .score(score), .game_over(game_over), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_empty(input logic [63:0] b);
    for (int i = 0; i < 16; i++) if (b[i*4 +: 4] == 4'd0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample just after the edge, let the board model absorb presets, drop pulses.
  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    key_valid = 1'b0; new_game = 1'b0; lane_done = 4'd0; score_in = 16'd0;
    if (inject_dir != 4'd0) inj_cycles++;
    if (in_wait) chk("no_preset_in_wait", 64'(preset_strobe), 64'd0);
    if (preset_strobe != 16'd0) begin
      chk("preset_vs_inject", 64'(inject_dir), 64'd0);
      if (preset_strobe == 16'hFFFF) begin
        clears++;
        chk("clear_value", 64'(preset_value), 64'd0);
        board_vec = 64'd0;
      end else begin
        spawns++;
        idx = 0;
        for (int i = 0; i < 16; i++) if (preset_strobe[i]) idx = i;
        chk("spawn_onehot", 64'($countones(preset_strobe)), 64'd1);
        chk("spawn_cell_empty", 64'(board_vec[idx*4 +: 4]), 64'd0);
        chk("spawn_value_1or2", 64'(preset_value == 4'd1 || preset_value == 4'd2), 64'd1);
        board_vec[idx*4 +: 4] = preset_value;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  // One key press and the grid's response; all_lanes=0 withholds lane 2 to force a timeout.
  task automatic run_move(input logic [3:0] key, input logic [63:0] after, input bit change,
                          input int delay, input bit all_lanes, input bit rand_score);
    int sp0, n, lim;
    logic [3:0] pending, ld;
    logic [15:0] s;
    bit exp_spawn;
    sp0 = spawns;
    inj_cycles = 0;
    key_valid = 1'b1;
    key_dir = key;
    tick();
    if ($countones(key) != 1) begin
      chk("ignored_key_busy", 64'(busy), 64'd0);
      tick();
      tick();
      chk("ignored_key_inject", 64'(inj_cycles), 64'd0);
      return;
    end
    chk("inject_dir", 64'(inject_dir), 64'(key));
    chk("busy_on_inject", 64'(busy), 64'd1);
    tick();
    chk("inject_one_cycle", 64'(inject_dir), 64'd0);
    in_wait = 1'b1;
    pending = 4'hF;
    n = 0;
    lim = all_lanes ? delay : TIMEOUT + 8;
    while (busy && n < lim) begin
      s = rand_score ? 16'($urandom) : ((n == 0) ? 16'h0001 : 16'h0000);
      score_in = s;
      exp_score += $countones(s);
      if (n == 0) begin
        if (change) board_vec = after;
        key_valid = 1'b1;
        key_dir = 4'(1 << $urandom_range(0, 3));
      end
      if (all_lanes) ld = (n == delay - 1) ? pending : (4'($urandom) & pending & 4'b0111);
      else ld = 4'($urandom) & 4'b1011;
      lane_done = ld;
      pending &= ~ld;
      tick();
      n++;
    end
    in_wait = 1'b0;
    if (all_lanes) begin
      chk("settle_busy", 64'(busy), 64'd1);
      s = rand_score ? 16'($urandom) : 16'h0000;
      score_in = s;
      exp_score += $countones(s);
      tick();
      exp_spawn = change && has_empty(after);
    end else begin
      chk("timeout_wait_cycles", 64'(n), 64'(TIMEOUT));
      chk("timeout_err_set", 64'(timeout_err), 64'd1);
      exp_spawn = 1'b0;
    end
    wait_idle(100);
    if (exp_score > 65535) exp_score = 65535;
    chk("spawn_count", 64'(spawns - sp0), 64'(exp_spawn));
    chk("inject_count", 64'(inj_cycles), 64'd1);
    chk("score", 64'(score), 64'(exp_score));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] after;
    logic [3:0] key;
    int k, sp0;
    bit full;
    rst = 1'b0; key_valid = 1'b0; key_dir = 4'd0; new_game = 1'b0;
    lane_done = 4'd0; score_in = 16'd0; movable_in = '1;

    repeat (3) tick();
    chk("rst_outputs", {inject_dir, preset_strobe, preset_value, busy, score, game_over, timeout_err},
        64'd0);

    rst = 1'b1;
    tick();
    chk("clear_strobe", 64'(preset_strobe), 64'hFFFF);
    chk("clear_busy", 64'(busy), 64'd1);
    wait_idle(100);
    chk("boot_clears", 64'(clears), 64'd1);
    chk("boot_spawns", 64'(spawns), 64'd2);
    chk("boot_score", 64'(score), 64'd0);

    // Left move merging cells 0 and 1 of row 0.
    board_vec = 64'h11;
    run_move(4'b0010, 64'h2, 1'b1, 3, 1'b1, 1'b0);
    chk("move1_score", 64'(score), 64'd1);

    run_move(4'b0110, 64'd0, 1'b0, 1, 1'b1, 1'b0);
    run_move(4'b0000, 64'd0, 1'b0, 1, 1'b1, 1'b0);
    run_move(4'b1000, 64'd0, 1'b0, 4, 1'b1, 1'b1);
    run_move(4'b0100, 64'd0, 1'b0, 1, 1'b0, 1'b1);

    for (int it = 0; it < 24; it++) begin
      full = (it % 5 == 4);
      board_vec = {32'($urandom), 32'($urandom)} & 64'h3333_3333_3333_3333;
      if (full) for (int i = 0; i < 16; i++) if (board_vec[i*4 +: 4] == 4'd0) board_vec[i*4 +: 4] = 4'd1;
      after = board_vec;
      k = $urandom_range(0, 15);
      if (full) after[k*4 +: 4] = (after[k*4 +: 4] == 4'd1) ? 4'd2 : 4'd1;
      else after[k*4 +: 4] = (after[k*4 +: 4] == 4'd0) ? 4'd1 : 4'd0;
      key = (it % 4 == 3) ? (4'($urandom) | 4'b0011) : 4'(1 << $urandom_range(0, 3));
      run_move(key, after, (it % 3 != 2), $urandom_range(1, 10), 1'b1, 1'b1);
    end
    chk("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // new_game in the middle of WAIT wins over the score update.
    key_valid = 1'b1; key_dir = 4'b0001;
    tick();
    tick();
    score_in = 16'hFFFF; new_game = 1'b1;
    tick();
    exp_score = 0;
    chk("midwait_clear_strobe", 64'(preset_strobe), 64'hFFFF);
    chk("midwait_score", 64'(score), 64'd0);
    chk("midwait_timeout_err", 64'(timeout_err), 64'd0);
    wait_idle(100);

    // Full checkerboard with no legal move.
    for (int i = 0; i < 16; i++) board_vec[i*4 +: 4] = (((i + i / 4) % 2) == 1) ? 4'd2 : 4'd1;
    movable_in = 64'd0;
    run_move(4'b1000, 64'd0, 1'b0, 2, 1'b1, 1'b1);
    chk("game_over_set", 64'(game_over), 64'd1);
    inj_cycles = 0;
    key_valid = 1'b1; key_dir = 4'b0001;
    tick();
    tick();
    chk("over_key_ignored", 64'(inj_cycles), 64'd0);
    chk("over_not_busy", 64'(busy), 64'd0);
    movable_in = '1;
    sp0 = spawns;
    new_game = 1'b1;
    tick();
    chk("newgame_clear_strobe", 64'(preset_strobe), 64'hFFFF);
    chk("newgame_game_over", 64'(game_over), 64'd0);
    chk("newgame_score", 64'(score), 64'd0);
    wait_idle(100);
    chk("newgame_spawns", 64'(spawns - sp0), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
